door_ctrl: RTL

//  Elevator door sequencer. Arrival at a floor, or the open button while parked, opens the door.
//  The door then holds open for a dwell time and closes. Open button holds or reopens the door;

---
 rtl/door_ctrl_pkg.sv | 35 +++
 rtl/door_tick_cnt.sv | 30 +++
 rtl/door_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/door_ctrl_pkg.sv
// Shared door sequencer definitions: state encodings, default tick constants, output flag payload.
package door_ctrl_pkg;

  localparam int unsigned WAIT_TICKS_DEF = 100;
  localparam int unsigned MOVE_TICKS_DEF = 50;
  localparam int unsigned CNT_W_DEF      = 7;

  typedef enum logic [1:0] {
    ST_CLOSED    = 2'd0,
    ST_OPENING   = 2'd1,
    ST_OPEN_WAIT = 2'd2,
    ST_CLOSING   = 2'd3
  } door_state_t;

  typedef struct packed {
    logic door_open;
    logic door_close;
    logic door_is_open;
    logic door_closed;
  } door_flags_t;

  // One-hot motor/status flags for a given door state.
  function automatic door_flags_t flags_of(input door_state_t st);
    door_flags_t f;
    f = '0;
    case (st)
      ST_CLOSED:    f.door_closed  = 1'b1;
      ST_OPENING:   f.door_open    = 1'b1;
      ST_OPEN_WAIT: f.door_is_open = 1'b1;
      ST_CLOSING:   f.door_close   = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/door_tick_cnt.sv
// Door travel/dwell tick counter: sync clear, parallel load, count enable, terminal compare.
module door_tick_cnt
#(
  parameter int unsigned CNT_W = 7
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/door_ctrl.sv
// Elevator door sequencer: open on arrival, dwell, close; buttons hold/reopen/shorten.
// Optional DOOR_OBSTRUCT_EN adds an obstruct input that reverses closing and holds the dwell.
module door_ctrl
  import door_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TICKS = WAIT_TICKS_DEF,
  parameter int unsigned MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             arr,
  input  logic             open_btn,
  input  logic             close_btn,
`ifdef DOOR_OBSTRUCT_EN
  input  logic             obstruct,
`endif
  output logic             door_open,
  output logic             door_close,
  output logic             door_is_open,
  output logic             door_closed,
  output logic [CNT_W-1:0] remain
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);

  door_state_t      state;
  door_flags_t      flags;
  logic             arr_q;
  logic             arr_rise;
  logic             go_open;
  logic             open_req;
  logic             cnt_clr;
  logic             cnt_ld;
  logic             cnt_en;
  logic             tc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc_val;
  logic [CNT_W-1:0] ld_val;

  assign arr_rise = arr & ~arr_q;
  assign go_open  = arr_rise | (arr & open_btn);

`ifdef DOOR_OBSTRUCT_EN
  assign open_req = open_btn | obstruct;
`else
  assign open_req = open_btn;
`endif

  // Dwell uses the wait terminal, both travel phases use the move terminal.
  assign tc_val = (state == ST_OPEN_WAIT) ? WAIT_LAST : MOVE_LAST;
  // Reversal travels back only the distance already closed.
  assign ld_val = MOVE_LAST - cnt;

  door_tick_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_ld),
    .en       (cnt_en),
    .load_val (ld_val),
    .tc_val   (tc_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Counter control, same priorities as the state transitions below.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      ST_CLOSED: cnt_clr = go_open;
      ST_OPENING: begin
        if (tc) cnt_clr = 1'b1;
        else    cnt_en  = 1'b1;
      end
      ST_OPEN_WAIT: begin
        if (open_req || close_btn || tc) cnt_clr = 1'b1;
        else                             cnt_en  = 1'b1;
      end
      ST_CLOSING: begin
        if (open_req) cnt_ld  = 1'b1;
        else if (tc)  cnt_clr = 1'b1;
        else          cnt_en  = 1'b1;
      end
    endcase
  end

  // Door FSM with flags and dwell countdown registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_CLOSED;
      arr_q  <= 1'b0;
      flags  <= flags_of(ST_CLOSED);
      remain <= '0;
    end else begin
      arr_q <= arr;
      case (state)
        ST_CLOSED: begin
          if (go_open) begin
            state <= ST_OPENING;
            flags <= flags_of(ST_OPENING);
          end
        end
        ST_OPENING: begin
          if (tc) begin
            state  <= ST_OPEN_WAIT;
            flags  <= flags_of(ST_OPEN_WAIT);
            remain <= WAIT_LAST;
          end
        end
        ST_OPEN_WAIT: begin
          if (open_req) begin
            remain <= WAIT_LAST;
          end else if (close_btn || tc) begin
            state  <= ST_CLOSING;
            flags  <= flags_of(ST_CLOSING);
            remain <= '0;
          end else begin
            remain <= remain - CNT_W'(1);
          end
        end
        ST_CLOSING: begin
          if (open_req) begin
            state <= ST_OPENING;
            flags <= flags_of(ST_OPENING);
          end else if (tc) begin
            state <= ST_CLOSED;
            flags <= flags_of(ST_CLOSED);
          end
        end
      endcase
    end
  end

  assign door_open    = flags.door_open;
  assign door_close   = flags.door_close;
  assign door_is_open = flags.door_is_open;
  assign door_closed  = flags.door_closed;

endmodule
